// File: rtl/cashier_lane_sched.sv
// ============================================================================
// Module   : cashier_lane_sched
// Purpose  : Round-robin scheduler sharing one Cashier among four checkout lanes
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cashier_lane_sched #(
  parameter int TIMEOUT = 15
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [3:0]  i_req,
  input  logic [63:0] i_payment,
  input  logic [47:0] i_item1_price,
  input  logic [11:0] i_item1_num,
  input  logic [47:0] i_item2_price,
  input  logic [11:0] i_item2_num,
  input  logic        i_cash_busy,
  input  logic        i_cash_valid,
  input  logic        i_cash_paid,
  input  logic [15:0] i_cash_change,
  output logic        o_cash_enable,
  output logic [15:0] o_cash_payment,
  output logic [11:0] o_cash_item1_price,
  output logic [2:0]  o_cash_item1_num,
  output logic [11:0] o_cash_item2_price,
  output logic [2:0]  o_cash_item2_num,
  output logic [3:0]  o_ack,
  output logic        o_done,
  output logic [1:0]  o_lane,
  output logic        o_paid,
  output logic        o_err,
  output logic [15:0] o_change,
  output logic [15:0] o_txn_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [3:0] c_timeout = 4'(TIMEOUT);

  // Per-lane views of the packed request buses
  logic [15:0] w_pay [4];
  logic [11:0] w_p1  [4];
  logic [2:0]  w_n1  [4];
  logic [11:0] w_p2  [4];
  logic [2:0]  w_n2  [4];

  for (genvar k = 0; k < 4; k++) begin : g_lane
    assign w_pay[k] = i_payment[16*k +: 16];
    assign w_p1[k]  = i_item1_price[12*k +: 12];
    assign w_n1[k]  = i_item1_num[3*k +: 3];
    assign w_p2[k]  = i_item2_price[12*k +: 12];
    assign w_n2[k]  = i_item2_num[3*k +: 3];
  end

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_rr_ptr, w_rr_ptr_nxt;
  logic [3:0]  r_tmo, w_tmo_nxt;
  logic        r_cash_enable, w_cash_enable_nxt;
  logic [15:0] r_cash_payment, w_cash_payment_nxt;
  logic [11:0] r_cash_item1_price, w_cash_item1_price_nxt;
  logic [2:0]  r_cash_item1_num, w_cash_item1_num_nxt;
  logic [11:0] r_cash_item2_price, w_cash_item2_price_nxt;
  logic [2:0]  r_cash_item2_num, w_cash_item2_num_nxt;
  logic [3:0]  r_ack, w_ack_nxt;
  logic        r_done, w_done_nxt;
  logic [1:0]  r_lane, w_lane_nxt;
  logic        r_paid, w_paid_nxt;
  logic        r_err, w_err_nxt;
  logic [15:0] r_change, w_change_nxt;
  logic [15:0] r_txn_count, w_txn_count_nxt;

  // Round-robin search: first requesting lane at or above the pointer, modulo 4
  logic       w_found;
  logic [1:0] w_winner;
  logic [1:0] w_idx;

  always_comb begin
    w_found  = 1'b0;
    w_winner = r_rr_ptr;
    w_idx    = r_rr_ptr;
    for (int k = 0; k < 4; k++) begin
      w_idx = r_rr_ptr + 2'(k);
      if (!w_found && i_req[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  always_comb begin
    w_state_nxt            = r_state;
    w_rr_ptr_nxt           = r_rr_ptr;
    w_tmo_nxt              = r_tmo;
    w_cash_enable_nxt      = 1'b0;
    w_cash_payment_nxt     = r_cash_payment;
    w_cash_item1_price_nxt = r_cash_item1_price;
    w_cash_item1_num_nxt   = r_cash_item1_num;
    w_cash_item2_price_nxt = r_cash_item2_price;
    w_cash_item2_num_nxt   = r_cash_item2_num;
    w_ack_nxt              = 4'b0000;
    w_done_nxt             = 1'b0;
    w_lane_nxt             = r_lane;
    w_paid_nxt             = 1'b0;
    w_err_nxt              = 1'b0;
    w_change_nxt           = 16'd0;
    w_txn_count_nxt        = r_txn_count;

    case (r_state)
      S_IDLE: begin
        if (w_found && !i_cash_busy) begin
          w_cash_payment_nxt     = w_pay[w_winner];
          w_cash_item1_price_nxt = w_p1[w_winner];
          w_cash_item1_num_nxt   = w_n1[w_winner];
          w_cash_item2_price_nxt = w_p2[w_winner];
          w_cash_item2_num_nxt   = w_n2[w_winner];
          w_lane_nxt             = w_winner;
          w_rr_ptr_nxt           = w_winner + 2'd1;
          // Enable and ack are registered, so they are raised on entry to ISSUE
          w_cash_enable_nxt      = 1'b1;
          w_ack_nxt              = 4'b0001 << w_winner;
          w_state_nxt            = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_tmo_nxt   = 4'd0;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (i_cash_valid) begin
          w_paid_nxt   = i_cash_paid;
          w_change_nxt = i_cash_change;
          w_done_nxt   = 1'b1;
          w_state_nxt  = S_DONE;
        end else if (r_tmo == c_timeout) begin
          w_err_nxt   = 1'b1;
          w_done_nxt  = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_tmo_nxt = r_tmo + 4'd1;
        end
      end
      S_DONE: begin
        w_txn_count_nxt = r_txn_count + {15'd0, r_paid};
        w_state_nxt     = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state            <= S_IDLE;
      r_rr_ptr           <= 2'd0;
      r_tmo              <= 4'd0;
      r_cash_enable      <= 1'b0;
      r_cash_payment     <= 16'd0;
      r_cash_item1_price <= 12'd0;
      r_cash_item1_num   <= 3'd0;
      r_cash_item2_price <= 12'd0;
      r_cash_item2_num   <= 3'd0;
      r_ack              <= 4'b0000;
      r_done             <= 1'b0;
      r_lane             <= 2'd0;
      r_paid             <= 1'b0;
      r_err              <= 1'b0;
      r_change           <= 16'd0;
      r_txn_count        <= 16'd0;
    end else begin
      r_state            <= w_state_nxt;
      r_rr_ptr           <= w_rr_ptr_nxt;
      r_tmo              <= w_tmo_nxt;
      r_cash_enable      <= w_cash_enable_nxt;
      r_cash_payment     <= w_cash_payment_nxt;
      r_cash_item1_price <= w_cash_item1_price_nxt;
      r_cash_item1_num   <= w_cash_item1_num_nxt;
      r_cash_item2_price <= w_cash_item2_price_nxt;
      r_cash_item2_num   <= w_cash_item2_num_nxt;
      r_ack              <= w_ack_nxt;
      r_done             <= w_done_nxt;
      r_lane             <= w_lane_nxt;
      r_paid             <= w_paid_nxt;
      r_err              <= w_err_nxt;
      r_change           <= w_change_nxt;
      r_txn_count        <= w_txn_count_nxt;
    end
  end

  assign o_cash_enable      = r_cash_enable;
  assign o_cash_payment     = r_cash_payment;
  assign o_cash_item1_price = r_cash_item1_price;
  assign o_cash_item1_num   = r_cash_item1_num;
  assign o_cash_item2_price = r_cash_item2_price;
  assign o_cash_item2_num   = r_cash_item2_num;
  assign o_ack              = r_ack;
  assign o_done             = r_done;
  assign o_lane             = r_lane;
  assign o_paid             = r_paid;
  assign o_err              = r_err;
  assign o_change           = r_change;
  assign o_txn_count        = r_txn_count;

endmodule

`default_nettype wire

// File: tb/tb_cashier_lane_sched.sv
// ============================================================================
// Module   : tb_cashier_lane_sched
// Purpose  : Directed scoreboard bench for cashier_lane_sched with a Cashier model
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cashier_lane_sched;

  localparam int TIMEOUT = 15;

  logic        i_clk;
  logic        i_rst;
  logic [3:0]  i_req;
  logic [63:0] i_payment;
  logic [47:0] i_item1_price;
  logic [11:0] i_item1_num;
  logic [47:0] i_item2_price;
  logic [11:0] i_item2_num;
  logic        i_cash_busy;
  logic        i_cash_valid;
  logic        i_cash_paid;
  logic [15:0] i_cash_change;
  logic        o_cash_enable;
  logic [15:0] o_cash_payment;
  logic [11:0] o_cash_item1_price;
  logic [2:0]  o_cash_item1_num;
  logic [11:0] o_cash_item2_price;
  logic [2:0]  o_cash_item2_num;
  logic [3:0]  o_ack;
  logic        o_done;
  logic [1:0]  o_lane;
  logic        o_paid;
  logic        o_err;
  logic [15:0] o_change;
  logic [15:0] o_txn_count;

  cashier_lane_sched #(.TIMEOUT(TIMEOUT)) dut (
    .i_clk              (i_clk),
    .i_rst              (i_rst),
    .i_req              (i_req),
    .i_payment          (i_payment),
    .i_item1_price      (i_item1_price),
    .i_item1_num        (i_item1_num),
    .i_item2_price      (i_item2_price),
    .i_item2_num        (i_item2_num),
    .i_cash_busy        (i_cash_busy),
    .i_cash_valid       (i_cash_valid),
    .i_cash_paid        (i_cash_paid),
    .i_cash_change      (i_cash_change),
    .o_cash_enable      (o_cash_enable),
    .o_cash_payment     (o_cash_payment),
    .o_cash_item1_price (o_cash_item1_price),
    .o_cash_item1_num   (o_cash_item1_num),
    .o_cash_item2_price (o_cash_item2_price),
    .o_cash_item2_num   (o_cash_item2_num),
    .o_ack              (o_ack),
    .o_done             (o_done),
    .o_lane             (o_lane),
    .o_paid             (o_paid),
    .o_err              (o_err),
    .o_change           (o_change),
    .o_txn_count        (o_txn_count)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [1:0]  lane;
    logic        paid;
    logic        err;
    logic [15:0] chg;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_cnt  = 16'd0;

  logic [15:0] pay [4];
  logic [11:0] p1  [4];
  logic [2:0]  n1  [4];
  logic [11:0] p2  [4];
  logic [2:0]  n2  [4];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_lane(input int k, input logic [15:0] pv, input logic [11:0] a,
                          input logic [2:0] an, input logic [11:0] b, input logic [2:0] bn);
    pay[k] = pv; p1[k] = a; n1[k] = an; p2[k] = b; n2[k] = bn;
    i_payment[16*k +: 16]     = pv;
    i_item1_price[12*k +: 12] = a;
    i_item1_num[3*k +: 3]     = an;
    i_item2_price[12*k +: 12] = b;
    i_item2_num[3*k +: 3]     = bn;
  endtask

  // Reference result for a lane: 16-bit payment minus total, zero on underpay
  task automatic push_exp(input int k, input bit timeout);
    exp_t e;
    int   tot;
    tot    = int'(p1[k]) * int'(n1[k]) + int'(p2[k]) * int'(n2[k]);
    e.lane = 2'(k);
    e.err  = timeout;
    e.paid = !timeout && (int'(pay[k]) >= tot);
    e.chg  = e.paid ? 16'(int'(pay[k]) - tot) : 16'd0;
    sb.push_back(e);
  endtask

  // Waits for the next grant, plays the Cashier, and scores the result
  task automatic serve(input bit respond);
    exp_t        e;
    int          n;
    int          lat;
    int          tot;
    logic        cp;
    logic [15:0] cc;
    logic [3:0]  exp_ack;
    n = 0;
    while (o_cash_enable !== 1'b1 && n < 40) begin
      @(negedge i_clk);
      n++;
    end
    chk("grant_seen", 64'(o_cash_enable), 64'd1);
    e = sb.pop_front();
    exp_ack = 4'b0001 << e.lane;
    chk("ack_onehot", 64'(o_ack), 64'(exp_ack));
    chk("lane_at_issue", 64'(o_lane), 64'(e.lane));
    chk("cash_fields",
        64'({o_cash_payment, o_cash_item1_price, o_cash_item1_num, o_cash_item2_price, o_cash_item2_num}),
        64'({pay[e.lane], p1[e.lane], n1[e.lane], p2[e.lane], n2[e.lane]}));
    i_req[e.lane] = 1'b0;
    tot = int'(o_cash_item1_price) * int'(o_cash_item1_num)
        + int'(o_cash_item2_price) * int'(o_cash_item2_num);
    cp  = int'(o_cash_payment) >= tot;
    cc  = cp ? 16'(int'(o_cash_payment) - tot) : 16'd0;
    lat = respond ? 10 : TIMEOUT + 2;
    n   = 0;
    do begin
      @(negedge i_clk);
      n++;
      if (respond && n == 9) begin
        i_cash_valid = 1'b1; i_cash_paid = cp; i_cash_change = cc;
      end else begin
        i_cash_valid = 1'b0; i_cash_paid = 1'b0; i_cash_change = 16'd0;
      end
      if (o_done !== 1'b1)
        chk("quiet_result", 64'({o_paid, o_err, o_change}), 64'd0);
    end while (o_done !== 1'b1 && n < 40);
    chk("done_latency", 64'(n), 64'(lat));
    chk("res_lane", 64'(o_lane), 64'(e.lane));
    chk("res_paid", 64'(o_paid), 64'(e.paid));
    chk("res_err", 64'(o_err), 64'(e.err));
    chk("res_change", 64'(o_change), 64'(e.chg));
    if (e.paid) exp_cnt = exp_cnt + 16'd1;
    @(negedge i_clk);
    chk("cleared_after_done", 64'({o_done, o_paid, o_err, o_change}), 64'd0);
    chk("txn_count", 64'(o_txn_count), 64'(exp_cnt));
  endtask

  initial begin
    i_rst = 1'b1; i_req = 4'b0000;
    i_payment = '0; i_item1_price = '0; i_item1_num = '0;
    i_item2_price = '0; i_item2_num = '0;
    i_cash_busy = 1'b0; i_cash_valid = 1'b0; i_cash_paid = 1'b0; i_cash_change = 16'd0;
    for (int k = 0; k < 4; k++) set_lane(k, 16'd0, 12'd0, 3'd0, 12'd0, 3'd0);
    repeat (2) @(negedge i_clk);
    chk("reset_ctl", 64'({o_cash_enable, o_ack, o_done, o_lane, o_paid, o_err, o_change, o_txn_count}), 64'd0);
    chk("reset_cash", 64'({o_cash_payment, o_cash_item1_price, o_cash_item1_num,
                           o_cash_item2_price, o_cash_item2_num}), 64'd0);
    i_rst = 1'b0;

    // Single lane, paid
    set_lane(0, 16'd10000, 12'd1000, 3'd3, 12'd500, 3'd2);
    i_req = 4'b0001; push_exp(0, 1'b0); serve(1'b1);

    // Underpay
    set_lane(2, 16'd1000, 12'd500, 3'd3, 12'd0, 3'd0);
    i_req = 4'b0100; push_exp(2, 1'b0); serve(1'b1);

    // Lane 3 at the arithmetic extremes; leaves the pointer at 0
    set_lane(3, 16'd65535, 12'd4095, 3'd7, 12'd4095, 3'd7);
    i_req = 4'b1000; push_exp(3, 1'b0); serve(1'b1);

    // Round-robin with all lanes pending
    set_lane(0, 16'd5000, 12'd100, 3'd2, 12'd200, 3'd1);
    set_lane(1, 16'd3000, 12'd250, 3'd4, 12'd0, 3'd0);
    set_lane(2, 16'd8000, 12'd1000, 3'd7, 12'd100, 3'd5);
    i_req = 4'b1111;
    for (int k = 0; k < 4; k++) push_exp(k, 1'b0);
    for (int k = 0; k < 4; k++) serve(1'b1);

    i_req = 4'b0101;
    push_exp(0, 1'b0); push_exp(2, 1'b0);
    serve(1'b1); serve(1'b1);

    i_req = 4'b1000; push_exp(3, 1'b0); serve(1'b1);
    i_req = 4'b0010; push_exp(1, 1'b0); serve(1'b1);

    // Timeout on lane 2, then lane 0 is served
    i_req = 4'b0101;
    push_exp(2, 1'b1); push_exp(0, 1'b0);
    serve(1'b0); serve(1'b1);

    // Busy hold
    i_cash_busy = 1'b1; i_req = 4'b0010;
    for (int k = 0; k < 20; k++) begin
      @(negedge i_clk);
      chk("busy_no_grant", 64'({o_cash_enable, o_ack}), 64'd0);
    end
    i_cash_busy = 1'b0;
    @(negedge i_clk);
    chk("grant_after_busy", 64'(o_cash_enable), 64'd1);
    push_exp(1, 1'b0); serve(1'b1);

    // Reset mid-WAIT
    i_req = 4'b0100;
    begin
      int n;
      n = 0;
      while (o_cash_enable !== 1'b1 && n < 40) begin
        @(negedge i_clk);
        n++;
      end
    end
    chk("abort_ack", 64'(o_ack), 64'b0100);
    i_req = 4'b0000;
    repeat (4) @(negedge i_clk);
    i_rst = 1'b1;
    #1;
    chk("abort_ctl", 64'({o_cash_enable, o_ack, o_done, o_lane, o_paid, o_err, o_change, o_txn_count}), 64'd0);
    chk("abort_cash", 64'({o_cash_payment, o_cash_item1_price, o_cash_item1_num,
                           o_cash_item2_price, o_cash_item2_num}), 64'd0);
    exp_cnt = 16'd0;
    @(negedge i_clk);
    i_req = 4'b1000;
    @(negedge i_clk);
    i_rst = 1'b0;
    push_exp(3, 1'b0); serve(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cashier_lane_sched.md
# cashier_lane_sched

Round-robin scheduler that shares one `Cashier` instance among four checkout lanes. It selects one pending lane and latches that lane's transaction. It issues a single-cycle enable to the `Cashier`, then waits for the `Cashier` result or a timeout. The result is returned on a shared bus tagged with the lane number. The block sits between the lane front-ends and the `Cashier`.

## Interface
- `TIMEOUT`, 15: maximum WAIT cycles for `i_cash_valid` before the transaction is failed (4-bit counter, 1..15).
- `i_clk` in 1: clock, rising edge.
- `i_rst` in 1: asynchronous, active-high reset.
- `i_req` in 4: per-lane request, level. Held high with stable data until the matching `o_ack` bit pulses.
- `i_payment` in 64: lane k at bits [16k+15:16k].
- `i_item1_price` in 48: lane k at bits [12k+11:12k].
- `i_item1_num` in 12: lane k at bits [3k+2:3k].
- `i_item2_price` in 48: packed like `i_item1_price`.
- `i_item2_num` in 12: packed like `i_item1_num`.
- `i_cash_busy` in 1: `Cashier` busy flag.
- `i_cash_valid` in 1: `Cashier` result strobe.
- `i_cash_paid` in 1: `Cashier` paid flag.
- `i_cash_change` in 16: `Cashier` change.
- `o_cash_enable` out 1: one-cycle start pulse to the `Cashier`.
- `o_cash_payment` out 16: latched transaction field to the `Cashier`.
- `o_cash_item1_price` out 12: latched transaction field to the `Cashier`.
- `o_cash_item1_num` out 3: latched transaction field to the `Cashier`.
- `o_cash_item2_price` out 12: latched transaction field to the `Cashier`.
- `o_cash_item2_num` out 3: latched transaction field to the `Cashier`.
- `o_ack` out 4: one-hot, one-cycle; the lane's request was accepted.
- `o_done` out 1: one-cycle result strobe.
- `o_lane` out 2: lane the result belongs to.
- `o_paid` out 1: result paid flag.
- `o_err` out 1: result timed out.
- `o_change` out 16: result change.
- `o_txn_count` out 16: count of completed transactions with `o_paid`=1; wraps at 65535→0.

## Operation
- States: IDLE, ISSUE, WAIT, DONE. All outputs are registered.
- **IDLE**
  - If `i_req`≠0 and `i_cash_busy`=0: select the winner by round-robin starting at `rr_ptr` and searching upward modulo 4.
  - Latch the winner's five fields into the `o_cash_*` registers, store the winner in `o_lane`, set `rr_ptr`=winner+1 mod 4, and go to ISSUE.
  - If `i_cash_busy`=1: stay in IDLE. No grant is made.
- **ISSUE**
  - `o_cash_enable`=1 and `o_ack[o_lane]`=1 for exactly this cycle.
  - Clear the timeout counter and go to WAIT.
- **WAIT**
  - Increment the timeout counter each cycle.
  - If `i_cash_valid`=1: capture `i_cash_paid` and `i_cash_change`, set `o_err`=0, go to DONE.
  - Else, if the counter reaches `TIMEOUT`: set `o_paid`=0, `o_change`=0, `o_err`=1, go to DONE.
  - `i_cash_valid` takes priority over timeout in the same cycle.
- **DONE**
  - `o_done`=1 for one cycle, with `o_lane`, `o_paid`, `o_err` and `o_change` valid.
  - Increment `o_txn_count` if `o_paid`=1. Go to IDLE.
- `o_paid`, `o_err` and `o_change` are 0 in every cycle where `o_done`=0.
- `o_cash_*` data fields hold their value until the next grant.
- The change is passed through as the `Cashier` computes it: 16-bit payment minus total; an underpayment gives paid=0 and change=0.
- `i_req` changes in WAIT or DONE are ignored until IDLE. A lane that drops its request before `o_ack` is never granted.
- `i_cash_valid` seen outside WAIT is ignored.

## Timing
- Reset state:
  - State=IDLE, `rr_ptr`=0, timeout counter=0.
  - All outputs 0, including every `o_cash_*` field and `o_txn_count`.
- Reset mid-transaction aborts immediately. The acked lane gets no `o_done`; after reset deassertion the block restarts in IDLE.
- Request seen in IDLE at edge t → ISSUE (`o_cash_enable`, `o_ack`) in cycle t+1 → WAIT from t+2.
- With the `Cashier` (valid 8 cycles after it samples enable), `o_done` occurs 10 cycles after `o_ack`.
- Timeout path: `o_done` with `o_err`=1 occurs `TIMEOUT`+2 cycles after `o_ack`.
- Back-to-back service: 1 IDLE cycle between DONE and the next ISSUE. Minimum spacing of `o_cash_enable` pulses is 12 cycles.
- At most one transaction is outstanding. `o_cash_enable` is never asserted when `i_cash_busy`=1 was sampled in IDLE.

## Test plan
- **Single lane, paid.** Lane 0: payment 10000, item1 1000×3, item2 500×2. Expect:
  - `o_ack`=0001, then 10 cycles later `o_done`.
  - Result: `o_lane`=0, `o_paid`=1, `o_change`=6000, `o_err`=0; `o_txn_count`=1.
- **Underpay.** Lane 2: payment 1000, item1 500×3, item2 0×0. Expect `o_done`, `o_lane`=2, `o_paid`=0, `o_change`=0; `o_txn_count` unchanged.
- **Round-robin.**
  - `i_req`=1111 held, re-raised after each ack → grants 0,1,2,3.
  - Then lanes 0 and 2 only → 0 then 2.
  - After the last grant was 3, a request from lane 1 alone → 1.
- **Timeout.** `i_cash_valid` tied 0. Expect `o_done` with `o_err`=1, `o_paid`=0, `o_change`=0, exactly 17 cycles after `o_ack`; then IDLE and the next lane is served.
- **Busy hold.** `i_cash_busy`=1 for 20 cycles with lane 1 requesting. Expect no `o_cash_enable` and no `o_ack`; grant occurs 1 cycle after busy falls.
- **Reset mid-WAIT.** Assert `i_rst` 4 cycles after `o_ack`. Expect all outputs 0 at once and no `o_done`; lane 3 requesting after release is granted first (`rr_ptr`=0 search order 0→3).
